// File: rtl/seg7_scan_capture_pkg.sv
// Shared segment table and types for the 7-segment scan capture path.
// The table matches the hex-to-segment encoder so readback decodes exactly what was driven.
package seg7_scan_capture_pkg;

  // Segments {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_HOLD
  } scan_state_e;

  typedef struct packed {
    logic       hit;    // pattern is one of the 16 hex glyphs
    logic       blank;  // all segments off
    logic [3:0] code;
  } seg_decode_t;

endpackage

// File: rtl/seg7_scan_capture_pattern_decode.sv
// Combinational reverse lookup of an active-low segment pattern to a hex code.
module seg7_pattern_decode
  import seg7_scan_capture_pkg::*;
(
  input  logic [6:0]  seg_i,
  output seg_decode_t dec_o
);

  always_comb begin
    dec_o       = '0;
    dec_o.hit   = 1'b1;
    case (seg_i)
      SEG_0:     dec_o.code = 4'h0;
      SEG_1:     dec_o.code = 4'h1;
      SEG_2:     dec_o.code = 4'h2;
      SEG_3:     dec_o.code = 4'h3;
      SEG_4:     dec_o.code = 4'h4;
      SEG_5:     dec_o.code = 4'h5;
      SEG_6:     dec_o.code = 4'h6;
      SEG_7:     dec_o.code = 4'h7;
      SEG_8:     dec_o.code = 4'h8;
      SEG_9:     dec_o.code = 4'h9;
      SEG_A:     dec_o.code = 4'hA;
      SEG_B:     dec_o.code = 4'hB;
      SEG_C:     dec_o.code = 4'hC;
      SEG_D:     dec_o.code = 4'hD;
      SEG_E:     dec_o.code = 4'hE;
      SEG_F:     dec_o.code = 4'hF;
      SEG_BLANK: begin
        dec_o.hit   = 1'b0;
        dec_o.blank = 1'b1;
      end
      default:   dec_o.hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Receive side of a multiplexed 7-segment bus: waits for each anode dwell to settle,
// decodes one sample per dwell and commits a digit after repeated identical samples.
module seg7_scan_capture
  import seg7_scan_capture_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned STABLE_SCANS  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] digit_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    bad_pattern,
  output logic                    frame_done
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [2:0]       MATCH_MAX = 3'(STABLE_SCANS);

  logic [6:0]              seg_s1_q, seg_s2_q, seg_prev_q;
  logic [NUM_DIGITS-1:0]   an_s1_q, an_s2_q;

  scan_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        k_q, k_d;
  logic [NUM_DIGITS-1:0]   an_lat_q, an_lat_d;

  logic [4:0]              cand_q  [NUM_DIGITS];
  logic [2:0]              match_q [NUM_DIGITS];
  logic [4*NUM_DIGITS-1:0] digit_q;
  logic [NUM_DIGITS-1:0]   valid_q, seen_q;
  logic                    bad_q, frame_q;

  // Synchronisers idle at "no anode active" so reset never looks like a dwell
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q   <= '1;
      seg_s2_q   <= '1;
      seg_prev_q <= '1;
      an_s1_q    <= '1;
      an_s2_q    <= '1;
    end else begin
      seg_s1_q   <= seg_in;
      seg_s2_q   <= seg_s1_q;
      seg_prev_q <= seg_s2_q;
      an_s1_q    <= an_in;
      an_s2_q    <= an_s1_q;
    end
  end

  logic [NUM_DIGITS-1:0] an_low;
  logic                  one_hot;
  logic [IDX_W-1:0]      an_idx;

  assign an_low  = ~an_s2_q;
  assign one_hot = (an_low != '0) && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);

  always_comb begin
    an_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (an_low[i]) an_idx = IDX_W'(i);
    end
  end

  logic an_changed, seg_changed, rescan, do_sample;

  assign an_changed  = (an_s2_q != an_lat_q);
  assign seg_changed = (seg_s2_q != seg_prev_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    an_lat_d  = an_lat_q;
    rescan    = 1'b0;
    do_sample = 1'b0;
    case (state_q)
      ST_IDLE:   rescan = 1'b1;
      ST_SETTLE: begin
        if (an_changed)            rescan = 1'b1;
        else if (seg_changed)      cnt_d = '0;
        else if (cnt_q == CNT_LAST) state_d = ST_SAMPLE;
        else                       cnt_d = cnt_q + CNT_W'(1);
      end
      ST_SAMPLE: begin
        do_sample = 1'b1;
        state_d   = ST_HOLD;
      end
      ST_HOLD:   rescan = an_changed;
      default:   state_d = ST_IDLE;
    endcase
    // A new anode pattern is judged in the same cycle it is seen, whatever the state
    if (rescan) begin
      if (one_hot) begin
        state_d  = ST_SETTLE;
        cnt_d    = '0;
        k_d      = an_idx;
        an_lat_d = an_s2_q;
      end else begin
        state_d  = ST_IDLE;
      end
    end
    if (clear) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      k_q      <= '0;
      an_lat_q <= '1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      an_lat_q <= an_lat_d;
    end
  end

  seg_decode_t dec;

  seg7_pattern_decode u_decode (
    .seg_i (seg_s2_q),
    .dec_o (dec)
  );

  logic [4:0]            sym, cand_cur;
  logic [2:0]            match_cur, match_new;
  logic                  same, reached;
  logic [NUM_DIGITS-1:0] seen_set;

  assign sym       = {dec.blank, dec.code};
  assign cand_cur  = cand_q[k_q];
  assign match_cur = match_q[k_q];
  assign same      = (cand_cur == sym);
  assign match_new = !same ? 3'd1 :
                     (match_cur == MATCH_MAX) ? match_cur : match_cur + 3'd1;
  // Commit only on the transition into saturation, including a fresh candidate when STABLE_SCANS is 1
  assign reached   = (match_new == MATCH_MAX) && !(same && match_cur == MATCH_MAX);
  assign seen_set  = seen_q | (NUM_DIGITS'(1) << k_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        cand_q[i]  <= '0;
        match_q[i] <= '0;
      end
      digit_q <= '0;
      valid_q <= '0;
      seen_q  <= '0;
      bad_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      bad_q   <= 1'b0;
      frame_q <= 1'b0;
      if (clear) begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) match_q[i] <= '0;
        valid_q <= '0;
        seen_q  <= '0;
      end else if (do_sample) begin
        if (dec.hit || dec.blank) begin
          cand_q[k_q]  <= sym;
          match_q[k_q] <= match_new;
          if (reached) begin
            if (dec.hit) begin
              digit_q[4*k_q +: 4] <= dec.code;
              valid_q[k_q]        <= 1'b1;
            end else begin
              valid_q[k_q]        <= 1'b0;
            end
          end
        end else begin
          bad_q        <= 1'b1;
          match_q[k_q] <= '0;
        end
        if (seen_set == '1) begin
          frame_q <= 1'b1;
          seen_q  <= '0;
        end else begin
          seen_q  <= seen_set;
        end
      end
    end
  end

  assign digit_out   = digit_q;
  assign digit_valid = valid_q;
  assign bad_pattern = bad_q;
  assign frame_done  = frame_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: directed scans plus random dwells against a dwell-level model.
module tb_seg7_scan_capture;

  localparam int N = 4;
  localparam int S = 16;
  localparam int T = 3;
  localparam int LONG = 40;
  localparam int SHORT = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [6:0]   seg_in;
  logic [N-1:0] an_in;
  logic         clear;
  logic [4*N-1:0] digit_out;
  logic [N-1:0] digit_valid;
  logic         bad_pattern;
  logic         frame_done;

  seg7_scan_capture #(
    .NUM_DIGITS    (N),
    .SETTLE_CYCLES (S),
    .STABLE_SCANS  (T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .clear       (clear),
    .digit_out   (digit_out),
    .digit_valid (digit_valid),
    .bad_pattern (bad_pattern),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  // index 0..15 hex glyphs, 16 = blank
  logic [6:0] segtab [17] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110,
    7'b1111111
  };
  localparam logic [6:0] BAD_SEG = 7'b0101010;

  int n_checks = 0;
  int n_bad    = 0;
  int bad_cnt  = 0;
  int frame_cnt = 0;

  // model: per-digit candidate (-1 none yet, 16 blank) and repeat count
  int           m_cand  [N];
  int           m_match [N];
  logic [4*N-1:0] m_out;
  logic [N-1:0] m_valid;
  logic [N-1:0] m_seen;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bad_pattern) bad_cnt++;
      if (frame_done)  frame_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [6:0] s);
    for (int i = 0; i < 17; i++) if (segtab[i] == s) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cand[i]  = -1;
      m_match[i] = 0;
    end
    m_out = '0; m_valid = '0; m_seen = '0;
  endtask

  task automatic model_sample(input int k, input logic [6:0] s, output int eb, output int ef);
    int c;
    bit commit;
    eb = 0; ef = 0; commit = 0;
    c = lookup(s);
    if (c < 0) begin
      eb = 1;
      m_match[k] = 0;
    end else begin
      if (m_cand[k] == c) begin
        if (m_match[k] < T) begin
          m_match[k]++;
          commit = (m_match[k] == T);
        end
      end else begin
        m_cand[k]  = c;
        m_match[k] = 1;
        commit = (T == 1);
      end
      if (commit) begin
        if (c == 16) m_valid[k] = 1'b0;
        else begin
          m_out[4*k +: 4] = 4'(c);
          m_valid[k] = 1'b1;
        end
      end
    end
    m_seen[k] = 1'b1;
    if (m_seen == '1) begin
      ef = 1;
      m_seen = '0;
    end
  endtask

  task automatic run_dwell(input logic [N-1:0] an, input logic [6:0] s, input int len);
    int b0, f0, eb, ef, k;
    b0 = bad_cnt; f0 = frame_cnt; eb = 0; ef = 0; k = -1;
    if ($countones(~an) == 1) begin
      for (int i = 0; i < N; i++) if (!an[i]) k = i;
    end
    an_in = an; seg_in = s;
    repeat (len) @(negedge clk);
    an_in = '1;
    repeat (4) @(negedge clk);
    if (k >= 0 && len >= S + 1) model_sample(k, s, eb, ef);
    check("bad_pulses", bad_cnt - b0, eb);
    check("frame_pulses", frame_cnt - f0, ef);
    check("digit_out", digit_out, m_out);
    check("digit_valid", digit_valid, m_valid);
  endtask

  task automatic run_frame(input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3);
    run_dwell(4'b1110, s0, LONG);
    run_dwell(4'b1101, s1, LONG);
    run_dwell(4'b1011, s2, LONG);
    run_dwell(4'b0111, s3, LONG);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout"}, digit_out, 0);
    check({tag, "_valid"}, digit_valid, 0);
    check({tag, "_bad"}, bad_pattern, 0);
    check({tag, "_frame"}, frame_done, 0);
  endtask

  initial begin
    int f_start, b0, f0, r, ri;
    logic [N-1:0] ran;
    logic [6:0]   rseg;

    rst_n = 1'b0; clear = 1'b0; an_in = '1; seg_in = '1;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // "1A3F" scanned for three frames
    f_start = frame_cnt;
    repeat (3) run_frame(segtab[1], segtab[10], segtab[3], segtab[15]);
    check("t1_dout", digit_out, 16'hF3A1);
    check("t1_valid", digit_valid, 4'hF);
    check("t1_frames", frame_cnt - f_start, 3);

    // digit 2: two frames of '2' never commit, third frame of '6' does
    repeat (2) run_frame(segtab[1], segtab[10], segtab[2], segtab[15]);
    check("t2_hold3", digit_out[11:8], 4'h3);
    repeat (2) run_frame(segtab[1], segtab[10], segtab[6], segtab[15]);
    check("t2_still3", digit_out[11:8], 4'h3);
    run_frame(segtab[1], segtab[10], segtab[6], segtab[15]);
    check("t2_now6", digit_out[11:8], 4'h6);
    run_frame(segtab[1], segtab[10], segtab[6], segtab[15]);

    // invalid pattern on digit 0
    b0 = bad_cnt;
    repeat (2) run_frame(BAD_SEG, segtab[10], segtab[6], segtab[15]);
    check("t3_bad_count", bad_cnt - b0, 2);
    check("t3_digit0", digit_out[3:0], 4'h1);
    check("t3_valid0", digit_valid[0], 1'b1);

    // short dwell and two-anode pattern never sample
    f0 = frame_cnt;
    run_dwell(4'b0111, segtab[15], SHORT);
    run_dwell(4'b1110, segtab[1], LONG);
    run_dwell(4'b1101, segtab[10], LONG);
    run_dwell(4'b1011, segtab[6], LONG);
    run_dwell(4'b1100, segtab[8], LONG);
    check("t4_no_frame", frame_cnt - f0, 0);
    run_dwell(4'b0111, segtab[15], LONG);
    check("t4_one_frame", frame_cnt - f0, 1);

    // blank on digit 1
    repeat (3) run_frame(segtab[1], segtab[16], segtab[6], segtab[15]);
    check("t5_valid1", digit_valid[1], 1'b0);
    check("t5_dout1", digit_out[7:4], 4'hA);

    // clear coinciding with the SAMPLE cycle of an invalid pattern
    run_frame(segtab[1], segtab[10], segtab[6], segtab[15]);
    b0 = bad_cnt; f0 = frame_cnt;
    an_in = 4'b1110; seg_in = BAD_SEG;
    repeat (S + 3) @(posedge clk);
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0; an_in = '1;
    repeat (6) @(negedge clk);
    m_valid = '0; m_seen = '0;
    for (int i = 0; i < N; i++) m_match[i] = 0;
    check("t6_clear_bad", bad_cnt - b0, 0);
    check("t6_clear_frame", frame_cnt - f0, 0);
    check("t6_clear_valid", digit_valid, 0);
    check("t6_clear_dout", digit_out, m_out);
    run_frame(segtab[7], segtab[10], segtab[6], segtab[15]);

    // reset mid-settle
    an_in = 4'b1101; seg_in = segtab[4];
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    repeat (2) @(negedge clk);
    an_in = '1;
    rst_n = 1'b1;
    model_reset();
    repeat (25) @(negedge clk);
    check_all_zero("rst_after");

    // random dwells
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 99);
      if (r < 85) begin
        ri = $urandom_range(0, N - 1);
        ran = ~(N'(1) << ri);
      end else begin
        ran = N'($urandom);
      end
      r = $urandom_range(0, 9);
      if (r < 7)       rseg = segtab[$urandom_range(0, 15)];
      else if (r == 7) rseg = segtab[16];
      else             rseg = 7'($urandom);
      run_dwell(ran, rseg, ($urandom_range(0, 4) == 0) ? SHORT : LONG);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
